// File: rtl/sd_pkg.sv
// Shared definitions for the signed-digit on-the-fly conversion datapath.
// Digit encodings, default frame length and converter FSM states.
package sd_pkg;

   localparam int SD_N = 8;

   localparam logic [1:0] SD_POS  = 2'b10;
   localparam logic [1:0] SD_NEG  = 2'b01;
   localparam logic [1:0] SD_ZERO = 2'b00;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } sd_state_e;

endpackage

// File: rtl/sd_otfc_step.sv
// One on-the-fly conversion step: appends a signed digit to Q and QM.
// Purely combinational; the caller owns the registers.
module sd_otfc_step
   import sd_pkg::*;
#(
   parameter int N = SD_N
) (
   input  logic [N:0] q,
   input  logic [N:0] qm,
   input  logic [1:0] dig,
   output logic [N:0] q_nx,
   output logic [N:0] qm_nx
);

   logic is_pos;
   logic is_neg;

   assign is_pos = (dig == SD_POS);
   assign is_neg = (dig == SD_NEG);

   always_comb begin
      q_nx  = {q[N-1:0], 1'b0};
      qm_nx = {qm[N-1:0], 1'b1};
      unique case (1'b1)
         is_pos: begin
            q_nx  = {q[N-1:0], 1'b1};
            qm_nx = {q[N-1:0], 1'b0};
         end
         is_neg: begin
            q_nx  = {qm[N-1:0], 1'b1};
            qm_nx = {qm[N-1:0], 1'b0};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/sd_otf_conv.sv
// MSB-first signed-digit to two's-complement on-the-fly converter.
// Optional ReLU clamp with early sign flag: define SD_OTF_CONV_RELU_EN.
module sd_otf_conv
   import sd_pkg::*;
#(
   parameter int N = SD_N
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       d_p,
   input  logic       d_n,
   input  logic       d_valid,
   input  logic       d_first,
   output logic [N:0] q,
   output logic       q_valid,
   output logic       busy,
   output logic       abort,
   output logic       neg_early
);

   localparam int CW = $clog2(N + 1);

   sd_state_e   state;
   logic [CW-1:0] cnt;
   logic [N:0]  q_r;
   logic [N:0]  qm_r;

   logic          start;
   logic          adv;
   logic          apply;
   logic          done;
   logic [CW-1:0] cnt_nx;
   logic [N:0]    base_q;
   logic [N:0]    base_qm;
   logic [N:0]    q_nx;
   logic [N:0]    qm_nx;
   logic [N:0]    q_fin;
   logic [1:0]    dig;

   assign dig     = {d_p, d_n};
   assign start   = d_valid & d_first;
   assign adv     = d_valid & ~d_first & (state == RUN);
   assign apply   = start | adv;
   assign cnt_nx  = start ? CW'(1) : cnt + CW'(1);
   assign done    = apply & (cnt_nx == CW'(N));
   assign base_q  = start ? '0 : q_r;
   assign base_qm = start ? '1 : qm_r;
   assign busy    = (state == RUN);

   sd_otfc_step #(.N(N)) u_step (
      .q     (base_q),
      .qm    (base_qm),
      .dig   (dig),
      .q_nx  (q_nx),
      .qm_nx (qm_nx)
   );

`ifdef SD_OTF_CONV_RELU_EN
   logic sign_set;
   logic sign_neg;
   logic dig_nz;
   logic dig_neg;
   logic neg_now;
   logic set_now;

   assign dig_nz  = (dig == SD_POS) | (dig == SD_NEG);
   assign dig_neg = (dig == SD_NEG);
   // A restart discards any sign already resolved for the old frame.
   assign set_now = start ? dig_nz  : (sign_set | dig_nz);
   assign neg_now = start ? dig_neg : (sign_set ? sign_neg : dig_neg);
   assign q_fin   = neg_now ? '0 : q_nx;

   always_ff @(posedge clk) begin
      if (rst) begin
         sign_set  <= 1'b0;
         sign_neg  <= 1'b0;
         neg_early <= 1'b0;
      end else begin
         neg_early <= 1'b0;
         if (apply) begin
            sign_set  <= done ? 1'b0 : set_now;
            sign_neg  <= done ? 1'b0 : neg_now;
            neg_early <= dig_neg & (start | ~sign_set);
         end
      end
   end
`else
   assign q_fin     = q_nx;
   assign neg_early = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         q_r     <= '0;
         qm_r    <= '0;
         q       <= '0;
         q_valid <= 1'b0;
         abort   <= 1'b0;
      end else begin
         q_valid <= 1'b0;
         abort   <= start & (state == RUN);
         if (apply) begin
            q_r  <= q_nx;
            qm_r <= qm_nx;
            if (done) begin
               state   <= IDLE;
               cnt     <= '0;
               q       <= q_fin;
               q_valid <= 1'b1;
            end else begin
               state <= RUN;
               cnt   <= cnt_nx;
            end
         end
      end
   end

endmodule

// File: tb/tb_sd_otf_conv.sv
// Directed self-checking bench for sd_otf_conv with N=4.
// Expected values are hand-computed digit sums.
module tb_sd_otf_conv;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       d_p;
   logic       d_n;
   logic       d_valid;
   logic       d_first;
   logic [N:0] q;
   logic       q_valid;
   logic       busy;
   logic       abort;
   logic       neg_early;

   int checks   = 0;
   int failures = 0;

   sd_otf_conv #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .d_p       (d_p),
      .d_n       (d_n),
      .d_valid   (d_valid),
      .d_first   (d_first),
      .q         (q),
      .q_valid   (q_valid),
      .busy      (busy),
      .abort     (abort),
      .neg_early (neg_early)
   );

   always #5 clk = ~clk;

   task automatic send(input int v, input bit first);
      d_p     = (v > 0);
      d_n     = (v < 0);
      d_valid = 1'b1;
      d_first = first;
      @(posedge clk);
      #1;
      d_valid = 1'b0;
      d_first = 1'b0;
      d_p     = 1'b0;
      d_n     = 1'b0;
   endtask

   task automatic bubble();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      d_p = 1'b0; d_n = 1'b0; d_valid = 1'b0; d_first = 1'b0;
      bubble();
      bubble();
      rst = 1'b0;
      bubble();
      checks++;
      if ({q, q_valid, busy, abort, neg_early} !== 9'b0) begin
         failures++;
         $display("FAIL reset outs got=%b want=%b",
                  {q, q_valid, busy, abort, neg_early}, 9'b0);
      end
   endtask

   task automatic test_ignored();
      send(1, 1'b0);
      checks++;
      if (busy !== 1'b0 || q_valid !== 1'b0) begin
         failures++;
         $display("FAIL ignored busy=%b qv=%b want 0 0", busy, q_valid);
      end
   endtask

   task automatic test_basic();
      send(1, 1'b1);
      send(0, 1'b0);
      send(-1, 1'b0);
      checks++;
      if (q_valid !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL basic mid qv=%b busy=%b want 0 1", q_valid, busy);
      end
      send(1, 1'b0);
      checks++;
      if (q_valid !== 1'b1 || q !== 5'b00111 || abort !== 1'b0) begin
         failures++;
         $display("FAIL basic q=%b qv=%b ab=%b want 00111 1 0",
                  q, q_valid, abort);
      end
      bubble();
      checks++;
      if (q_valid !== 1'b0 || q !== 5'b00111) begin
         failures++;
         $display("FAIL basic hold q=%b qv=%b want 00111 0", q, q_valid);
      end
   endtask

   task automatic test_neg();
      logic [N:0] exp_q;
      logic       exp_ne;
`ifdef SD_OTF_CONV_RELU_EN
      exp_q  = 5'b00000;
      exp_ne = 1'b1;
`else
      exp_q  = 5'b11111;
      exp_ne = 1'b0;
`endif
      send(-1, 1'b1);
      checks++;
      if (neg_early !== exp_ne) begin
         failures++;
         $display("FAIL neg_early got=%b want=%b", neg_early, exp_ne);
      end
      send(1, 1'b0);
      checks++;
      if (neg_early !== 1'b0) begin
         failures++;
         $display("FAIL neg_early once got=%b want=0", neg_early);
      end
      send(1, 1'b0);
      send(1, 1'b0);
      checks++;
      if (q_valid !== 1'b1 || q !== exp_q) begin
         failures++;
         $display("FAIL neg q=%b qv=%b want %b 1", q, q_valid, exp_q);
      end
   endtask

   task automatic test_bubbles();
      int bad = 0;
      send(-1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         bubble();
         if (busy !== 1'b1 || q_valid !== 1'b0) bad++;
         send(-1, 1'b0);
         if (i < 2 && (busy !== 1'b1 || q_valid !== 1'b0)) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL bubbles busy/qv glitches got=%0d want=0", bad);
      end
      checks++;
      if (q_valid !== 1'b1 || q !== 5'b10001) begin
         failures++;
         $display("FAIL bubbles q=%b qv=%b want 10001 1", q, q_valid);
      end
   endtask

   task automatic test_restart();
      int aborts = 0;
      int qvs    = 0;
      send(1, 1'b1);
      aborts += abort; qvs += q_valid;
      send(1, 1'b0);
      aborts += abort; qvs += q_valid;
      send(-1, 1'b1);
      checks++;
      if (abort !== 1'b1) begin
         failures++;
         $display("FAIL restart abort got=%b want=1", abort);
      end
      aborts += abort; qvs += q_valid;
      send(0, 1'b0);
      aborts += abort; qvs += q_valid;
      send(0, 1'b0);
      aborts += abort; qvs += q_valid;
      send(0, 1'b0);
      aborts += abort;
      checks++;
      if (aborts != 1 || qvs != 0) begin
         failures++;
         $display("FAIL restart counts ab=%0d qv=%0d want 1 0", aborts, qvs);
      end
      checks++;
      if (q_valid !== 1'b1 || q !== 5'b11000) begin
         failures++;
         $display("FAIL restart q=%b qv=%b want 11000 1", q, q_valid);
      end
   endtask

   task automatic test_back_to_back();
      int v [8] = '{1, 1, 1, 1, 0, 0, 0, 1};
      int pulse [$];
      logic [N:0] vals [$];
      for (int i = 0; i < 8; i++) begin
         send(v[i], (i % 4) == 0);
         if (q_valid === 1'b1) begin
            pulse.push_back(i);
            vals.push_back(q);
         end
         if (abort !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL b2b abort at digit %0d got=1 want=0", i);
         end
      end
      checks++;
      if (pulse.size() != 2) begin
         failures++;
         $display("FAIL b2b pulses got=%0d want=2", pulse.size());
      end else begin
         checks++;
         if (pulse[0] != 3 || pulse[1] != 7) begin
            failures++;
            $display("FAIL b2b timing got=%0d,%0d want=3,7",
                     pulse[0], pulse[1]);
         end
         checks++;
         if (vals[0] !== 5'd15 || vals[1] !== 5'd1) begin
            failures++;
            $display("FAIL b2b q got=%0d,%0d want=15,1", vals[0], vals[1]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int bad = 0;
      send(1, 1'b1);
      send(-1, 1'b0);
      rst = 1'b1;
      bubble();
      rst = 1'b0;
      checks++;
      if (q_valid !== 1'b0 || busy !== 1'b0 || abort !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid qv=%b busy=%b ab=%b want 0 0 0",
                  q_valid, busy, abort);
      end
      send(0, 1'b1);
      bad += abort + q_valid;
      send(1, 1'b0);
      bad += abort + q_valid;
      send(0, 1'b0);
      bad += abort + q_valid;
      send(0, 1'b0);
      bad += abort;
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL rst_mid stray pulses got=%0d want=0", bad);
      end
      checks++;
      if (q_valid !== 1'b1 || q !== 5'd4) begin
         failures++;
         $display("FAIL rst_mid q=%0d qv=%b want 4 1", q, q_valid);
      end
   endtask

   initial begin
      test_reset();
      test_ignored();
      test_basic();
      test_neg();
      bubble();
      test_bubbles();
      bubble();
      test_restart();
      bubble();
      test_back_to_back();
      bubble();
      test_reset_mid();
      bubble();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sd_otf_conv.md
# sd_otf_conv

- Digit-serial, MSB-first on-the-fly converter (OTFC).
- Accepts a frame of N signed-digit (redundant binary, p/n encoded) digits, as produced by the online adder/multiplier chain.
- Delivers the conventional two's-complement result one cycle after the last digit.
- Sits at the output end of the online-arithmetic datapath, feeding activation storage and any downstream parallel logic.

## Interface
- N, 8: digits per frame; result width N+1
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- d_p  in  1  positive rail of incoming digit
- d_n  in  1  negative rail of incoming digit
- d_valid  in  1  digit on d_p/d_n is valid this cycle
- d_first  in  1  qualifies d_valid; marks the first (most significant) digit of a frame
- q  out  N+1  signed result, integer scale: q = sum d_i·2^(N-i), i=1..N
- q_valid  out  1  one-cycle pulse; q holds a completed frame
- busy  out  1  frame in progress (between first and last digit)
- abort  out  1  one-cycle pulse; a frame was discarded by a restart
- neg_early  out  1  one-cycle pulse; frame sign resolved negative (see Configuration)

## Operation
- Digit value = d_p − d_n: 10→+1, 01→−1, 00 and 11→0.
- Registers Q and QM, each N+1 bits.
- On a frame start, Q=0 and QM=all-ones (−1) before the first digit is applied.
- Per accepted digit, with {X,b} meaning X shifted left with b appended at the LSB:
  - +1: Q←{Q,1}, QM←{Q,0}
  - 0: Q←{Q,0}, QM←{QM,1}
  - −1: Q←{QM,1}, QM←{QM,0}
- Digit counter cnt counts 0..N−1. States: IDLE, RUN.
- IDLE:
  - d_valid&d_first → apply the digit from the init values, cnt=1, go to RUN. If N=1, complete immediately.
  - d_valid without d_first → digit ignored.
- RUN:
  - d_valid&!d_first → apply digit, cnt++.
  - On the N-th digit: load q, pulse q_valid next cycle, go to IDLE.
  - d_valid low → stall; state unchanged.
- Restart: d_valid&d_first in RUN → pulse abort, re-init, treat the digit as digit 1 of a new frame.
- Back-to-back frames: d_first in the cycle after the last digit is accepted with no bubble. q_valid for the old frame and the first digit of the new frame coincide.
- q holds its value until the next completion.
- No overflow is possible: |result| ≤ 2^N−1 fits in N+1 bits.

## Timing
- Reset values: q=0, q_valid=0, busy=0, abort=0, neg_early=0, state IDLE, cnt=0.
- Reset mid-frame discards the frame silently (no abort).
- Latency: q/q_valid registered, valid in the cycle after the N-th accepted digit.
- busy is registered: high from the cycle after the first digit until the cycle after the last digit.
- abort is registered, one cycle after the restarting digit.
- Throughput: one digit per cycle, one frame per N cycles.

## Configuration
- Macro: SD_OTF_CONV_RELU_EN.
- Defined:
  - The first nonzero digit of a frame fixes its sign.
  - If that digit is −1, neg_early pulses the next cycle, once per frame.
  - The remaining digits are still consumed and counted.
  - The final q is forced to 0 (ReLU).
  - Abort clears the pending sign.
- Undefined: neg_early is tied 0 and q is unclamped. Sign-tracking logic is absent.

## Structure
- Shared package sd_pkg holds:
  - digit encoding constants (SD_POS=2'b10, SD_NEG=2'b01, SD_ZERO=2'b00)
  - the default N
  - the state enum {IDLE, RUN}
- One sub-module: sd_otfc_step. It is combinational: it takes Q, QM and a digit and returns the next Q and QM. The top-level module holds the registers, counter, FSM and the ReLU logic.

## Test plan
All cases use N=4.
- Digits +1,0,−1,+1 contiguous → q=5'b00111 (7), q_valid one cycle after the 4th digit, abort=0.
- Digits −1,+1,+1,+1 → q=5'b11111 (−1); without the macro neg_early=0. With SD_OTF_CONV_RELU_EN: neg_early pulses after digit 1 and q=0.
- Digits −1,−1,−1,−1 with one-cycle bubbles between digits → q=5'b10001 (−15), q_valid 1 cycle after the last digit, busy high throughout.
- Digits +1,+1, then d_first with −1,0,0,0 → abort pulse once, q=5'b11000 (−8).
- Two back-to-back frames (+1,+1,+1,+1 then 0,0,0,+1) → q=15, then q=1, on consecutive q_valid pulses 4 cycles apart.
- rst asserted after 2 digits, then a full frame 0,+1,0,0 → no q_valid for the partial frame, then q=4, abort=0.
